// File: rtl/preadd_sched_pkg.sv
// Shared constants and helpers for the pre-add/multiply scheduler.
// PM_LAT is the datapath latency; the tag pipeline depth is tied to it.
package preadd_sched_pkg;

  localparam int PM_LAT = 4;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/preadd_mult.sv
// Pipelined (a + d) * b with full-precision signed result and 4-cycle latency.
// All stages advance together on ce so a stalled result holds in place.
module preadd_mult #(
  parameter int AW = 16,
  parameter int BW = 18,
  parameter int MW = AW + 1 + BW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic signed [AW-1:0] a,
  input  logic signed [AW-1:0] d,
  input  logic signed [BW-1:0] b,
  output logic signed [MW-1:0] p
);

  function automatic logic signed [AW:0] preadd(input logic signed [AW-1:0] x,
                                                input logic signed [AW-1:0] y);
    return (AW+1)'(x) + (AW+1)'(y);
  endfunction

  logic signed [AW-1:0] a_p0_q, a_p0_d, d_p0_q, d_p0_d;
  logic signed [BW-1:0] b_p0_q, b_p0_d, b_p1_q, b_p1_d;
  logic signed [AW:0]   sum_p1_q, sum_p1_d;
  logic signed [MW-1:0] prod_p2_q, prod_p2_d;
  logic signed [MW-1:0] p_p3_q, p_p3_d;

  always_comb begin
    a_p0_d    = a_p0_q;
    d_p0_d    = d_p0_q;
    b_p0_d    = b_p0_q;
    sum_p1_d  = sum_p1_q;
    b_p1_d    = b_p1_q;
    prod_p2_d = prod_p2_q;
    p_p3_d    = p_p3_q;
    if (ce) begin
      // p0: operand capture
      a_p0_d    = a;
      d_p0_d    = d;
      b_p0_d    = b;
      // p1: sign-extended pre-add
      sum_p1_d  = preadd(a_p0_q, d_p0_q);
      b_p1_d    = b_p0_q;
      // p2: full-width signed product
      prod_p2_d = MW'(sum_p1_q) * MW'(b_p1_q);
      // p3: output register
      p_p3_d    = prod_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_p0_q    <= '0;
      d_p0_q    <= '0;
      b_p0_q    <= '0;
      sum_p1_q  <= '0;
      b_p1_q    <= '0;
      prod_p2_q <= '0;
      p_p3_q    <= '0;
    end else begin
      a_p0_q    <= a_p0_d;
      d_p0_q    <= d_p0_d;
      b_p0_q    <= b_p0_d;
      sum_p1_q  <= sum_p1_d;
      b_p1_q    <= b_p1_d;
      prod_p2_q <= prod_p2_d;
      p_p3_q    <= p_p3_d;
    end
  end

  assign p = p_p3_q;

endmodule

// File: rtl/preadd_mult_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant
);

  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant       = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/preadd_mult_sched.sv
// Shares one preadd_mult among NREQ requesters with round-robin arbitration;
// each result carries the issuing requester's ID and the pipe stalls on backpressure.
module preadd_mult_sched
  import preadd_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int BW   = 18,
  parameter int MW   = AW + 1 + BW,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][AW-1:0]  req_a,
  input  logic [NREQ-1:0][AW-1:0]  req_d,
  input  logic [NREQ-1:0][BW-1:0]  req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [IDW-1:0]           res_id,
  output logic signed [MW-1:0]     res_p
);

  logic                 ce;
  logic                 accept;
  logic                 grant_valid;
  logic [IDW-1:0]       grant;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PM_LAT-1:0]    vld_q, vld_d;
  logic [IDW-1:0]       id_q [PM_LAT];
  logic [IDW-1:0]       id_d [PM_LAT];
  logic signed [AW-1:0] op_a, op_d;
  logic signed [BW-1:0] op_b;

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Whole pipe freezes only while a result is waiting and the sink refuses it.
  assign ce     = !(res_valid && !res_ready);
  assign accept = ce && !rst && grant_valid;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  assign op_a = $signed(req_a[grant]);
  assign op_d = $signed(req_d[grant]);
  assign op_b = $signed(req_b[grant]);

  preadd_mult #(.AW(AW), .BW(BW), .MW(MW)) u_dp (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .a   (op_a),
    .d   (op_d),
    .b   (op_b),
    .p   (res_p)
  );

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    vld_d    = vld_q;
    id_d     = id_q;
    if (accept) rr_ptr_d = IDW'(rr_next(int'(grant), NREQ));
    if (ce) begin
      // p0: tag enters alongside the operands
      vld_d[0] = accept;
      id_d[0]  = accept ? grant : '0;
      for (int s = 1; s < PM_LAT; s++) begin
        vld_d[s] = vld_q[s-1];
        id_d[s]  = id_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      vld_q    <= '0;
      for (int s = 0; s < PM_LAT; s++) id_q[s] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vld_q    <= vld_d;
      id_q     <= id_d;
    end
  end

  assign res_valid = vld_q[PM_LAT-1];
  assign res_id    = id_q[PM_LAT-1];

endmodule

// File: tb/tb_preadd_mult_sched.sv
// Directed bench for preadd_mult_sched with a transaction-level reference model
// (round-robin pointer, queue of expected results with due cycles).
module tb_preadd_mult_sched;

  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int BW   = 18;
  localparam int MW   = AW + 1 + BW;
  localparam int IDW  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][AW-1:0] req_a;
  logic [NREQ-1:0][AW-1:0] req_d;
  logic [NREQ-1:0][BW-1:0] req_b;
  logic                    res_valid;
  logic                    res_ready;
  logic [IDW-1:0]          res_id;
  logic signed [MW-1:0]    res_p;

  preadd_mult_sched #(.NREQ(NREQ), .AW(AW), .BW(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_d     (req_d),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_p     (res_p)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int d, input int b);
    req_a[i] = a[AW-1:0];
    req_d[i] = d[AW-1:0];
    req_b[i] = b[BW-1:0];
  endtask

  // Reference model: expected results in issue order, each due 4 cycles after
  // acceptance plus however many stall cycles occurred since.
  typedef struct {
    int     id;
    longint p;
    int     c;
    int     st;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   stall_total = 0;
  int   n_results = 0;
  int   m_ptr = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_on) begin
      bit     exp_vld;
      bit     m_ce;
      int     g;
      int     idx;
      logic [NREQ-1:0] exp_rdy;
      exp_t   e;
      exp_vld = 1'b0;
      if (q.size() > 0) exp_vld = (cyc >= q[0].c + 4 + stall_total - q[0].st);
      m_ce = !(exp_vld && !res_ready);
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      exp_rdy = '0;
      if (!rst && m_ce && g >= 0) exp_rdy[g] = 1'b1;
      chk("mon_req_ready", longint'(req_ready), longint'(exp_rdy));
      chk("mon_res_valid", longint'(res_valid), longint'(exp_vld));
      if (exp_vld) begin
        chk("mon_res_id", longint'(res_id), longint'(q[0].id));
        chk("mon_res_p", longint'(res_p), q[0].p);
      end
      if (rst) begin
        q.delete();
        m_ptr = 0;
      end else begin
        if (exp_vld && !res_ready) stall_total++;
        if (exp_vld && res_ready) begin
          void'(q.pop_front());
          n_results++;
        end
        if (exp_rdy != '0) begin
          e.id = g;
          e.p  = (longint'($signed(req_a[g])) + longint'($signed(req_d[g])))
                 * longint'($signed(req_b[g]));
          e.c  = cyc;
          e.st = stall_total;
          q.push_back(e);
          m_ptr = (g + 1) % NREQ;
        end
      end
    end
  end

  int got[8];
  int n0;

  initial begin
    rst       = 1'b1;
    res_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_op(i, 100 * (i + 1), -i, i - 3);

    // Reset: outputs cleared and no acceptance even with every requester valid
    tick();
    tick();
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_res_valid", longint'(res_valid), 0);
    chk("rst_res_id", longint'(res_id), 0);
    chk("rst_res_p", longint'(res_p), 0);
    chk("rst_req_ready", longint'(req_ready), 0);
    tick();
    rst       = 1'b0;
    req_valid = '0;

    // Single op from requester 2: (100 - 30) * 5
    set_op(2, 100, -30, 5);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", longint'(req_ready), 4);
    tick();
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("single_early", longint'(res_valid), 0);
    @(negedge clk);
    chk("single_valid", longint'(res_valid), 1);
    chk("single_p", longint'(res_p), 350);
    chk("single_id", longint'(res_id), 2);
    tick();

    // Full contention from a fresh pointer
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 100 * (i + 1), -i, i - 3);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      got[k] = -1;
      for (int j = 0; j < NREQ; j++) if (req_ready[j]) got[k] = j;
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 8; k++) chk($sformatf("rr_order_%0d", k), got[k], k % 4);
    repeat (6) tick();

    // Backpressure: three ops, sink refuses for 5 cycles from first result
    n0 = n_results;
    set_op(1, 1000, 234, -7);
    req_valid = 4'b0010;
    tick();
    set_op(1, -5, -5, 100);
    tick();
    set_op(1, 32767, -1, 3);
    tick();
    req_valid = '0;
    res_ready = 1'b0;
    @(negedge clk);
    chk("bp_not_yet", longint'(res_valid), 0);
    tick();
    set_op(3, 7, 8, 9);
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", longint'(res_valid), 1);
      chk("bp_hold_p", longint'(res_p), -8638);
      chk("bp_hold_id", longint'(res_id), 1);
      chk("bp_no_ready", longint'(req_ready), 0);
      tick();
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", longint'(req_ready), 8);
    chk("bp_release_p", longint'(res_p), -8638);
    tick();
    req_valid = '0;
    repeat (10) tick();
    chk("bp_result_count", n_results - n0, 4);

    // Operand extremes: (-65536) * (-131072) and 65534 * 131071
    set_op(0, -32768, -32768, -131072);
    req_valid = 4'b0001;
    tick();
    set_op(0, 32767, 32767, 131071);
    tick();
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("ext_min_p", longint'(res_p), 64'sd8589934592);
    chk("ext_min_id", longint'(res_id), 0);
    @(negedge clk);
    chk("ext_max_p", longint'(res_p), 64'sd8589606914);
    tick();
    repeat (4) tick();

    // Sparse: requester 3 alone on alternate cycles, then pointer must wrap to 0
    for (int k = 0; k < 4; k++) begin
      set_op(3, 11 * k + 1, -k, k + 1);
      req_valid = 4'b1000;
      @(negedge clk);
      chk("sparse_ready", longint'(req_ready), 8);
      tick();
      req_valid = '0;
      tick();
    end
    req_valid = '1;
    @(negedge clk);
    chk("sparse_wrap", longint'(req_ready), 1);
    tick();
    req_valid = '0;
    repeat (6) tick();

    // Reset mid-flight: two ops in the pipe are discarded
    set_op(1, 5, 6, 7);
    set_op(2, -8, 3, 2);
    req_valid = 4'b0110;
    tick();
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midrst_no_valid", longint'(res_valid), 0);
      tick();
    end
    req_valid = '1;
    @(negedge clk);
    chk("midrst_first_grant", longint'(req_ready), 1);
    tick();
    req_valid = '0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
